friscv_axi_rd_arbiter: RTL

//  Shares one AXI4 read port to central memory between two cache memory controllers:

---
 rtl/friscv_axi_rd_arbiter.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/friscv_axi_rd_arbiter.sv
// Two-slave AXI4 read arbiter: registered round-robin AR slot toward memory,
// zero-latency R steering by ID mask, capped outstanding bursts per slave.
module friscv_axi_rd_arbiter #(
  parameter int AXI_ADDR_W  = 32,
  parameter int AXI_ID_W    = 8,
  parameter int AXI_DATA_W  = 128,
  parameter int OSTDREQ_NUM = 8,
  parameter int S0_ID_MASK  = 32'h10,
  parameter int S1_ID_MASK  = 32'h20
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  // slave 0 (icache)
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  input  logic [AXI_ADDR_W-1:0] s0_araddr,
  input  logic [7:0]            s0_arlen,
  input  logic [2:0]            s0_arsize,
  input  logic [1:0]            s0_arburst,
  input  logic [1:0]            s0_arlock,
  input  logic [3:0]            s0_arcache,
  input  logic [2:0]            s0_arprot,
  input  logic [3:0]            s0_arqos,
  input  logic [3:0]            s0_arregion,
  input  logic [AXI_ID_W-1:0]   s0_arid,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  output logic [AXI_ID_W-1:0]   s0_rid,
  output logic [1:0]            s0_rresp,
  output logic [AXI_DATA_W-1:0] s0_rdata,
  output logic                  s0_rlast,
  // slave 1 (dcache)
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  input  logic [AXI_ADDR_W-1:0] s1_araddr,
  input  logic [7:0]            s1_arlen,
  input  logic [2:0]            s1_arsize,
  input  logic [1:0]            s1_arburst,
  input  logic [1:0]            s1_arlock,
  input  logic [3:0]            s1_arcache,
  input  logic [2:0]            s1_arprot,
  input  logic [3:0]            s1_arqos,
  input  logic [3:0]            s1_arregion,
  input  logic [AXI_ID_W-1:0]   s1_arid,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  output logic [AXI_ID_W-1:0]   s1_rid,
  output logic [1:0]            s1_rresp,
  output logic [AXI_DATA_W-1:0] s1_rdata,
  output logic                  s1_rlast,
  // memory
  output logic                  mem_arvalid,
  input  logic                  mem_arready,
  output logic [AXI_ADDR_W-1:0] mem_araddr,
  output logic [7:0]            mem_arlen,
  output logic [2:0]            mem_arsize,
  output logic [1:0]            mem_arburst,
  output logic [1:0]            mem_arlock,
  output logic [3:0]            mem_arcache,
  output logic [2:0]            mem_arprot,
  output logic [3:0]            mem_arqos,
  output logic [3:0]            mem_arregion,
  output logic [AXI_ID_W-1:0]   mem_arid,
  input  logic                  mem_rvalid,
  output logic                  mem_rready,
  input  logic [AXI_ID_W-1:0]   mem_rid,
  input  logic [1:0]            mem_rresp,
  input  logic [AXI_DATA_W-1:0] mem_rdata,
  input  logic                  mem_rlast,
  output logic                  route_err
);

  localparam int CNT_W = $clog2(OSTDREQ_NUM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OSTDREQ_NUM);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [AXI_ID_W-1:0] S0_MASK = AXI_ID_W'(S0_ID_MASK);
  localparam logic [AXI_ID_W-1:0] S1_MASK = AXI_ID_W'(S1_ID_MASK);
  localparam int AR_W = AXI_ADDR_W + 8 + 3 + 2 + 2 + 4 + 3 + 4 + 4 + AXI_ID_W;

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
    logic [CNT_W-1:0] res;
    case ({inc, dec})
      2'b10:   res = (cnt < CNT_MAX) ? cnt + CNT_ONE : cnt;
      2'b01:   res = (cnt != '0) ? cnt - CNT_ONE : cnt;
      default: res = cnt;
    endcase
    return res;
  endfunction

  logic            rst_s;
  logic            slot_free_s;
  logic            elig0_s, elig1_s;
  logic            grant0_s, grant1_s;
  logic            hit0_s, hit1_s;
  logic            dec0_s, dec1_s;
  logic            ptr_r;
  logic            mem_arvalid_r;
  logic            route_err_r;
  logic [CNT_W-1:0] cnt0_r, cnt1_r;
  logic [AR_W-1:0] s0_ar_s, s1_ar_s, mem_ar_r;

  assign rst_s = !aresetn || srst;

  assign s0_ar_s = {s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_arlock,
                    s0_arcache, s0_arprot, s0_arqos, s0_arregion, s0_arid};
  assign s1_ar_s = {s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_arlock,
                    s1_arcache, s1_arprot, s1_arqos, s1_arregion, s1_arid};
  assign {mem_araddr, mem_arlen, mem_arsize, mem_arburst, mem_arlock,
          mem_arcache, mem_arprot, mem_arqos, mem_arregion, mem_arid} = mem_ar_r;

  assign slot_free_s = !mem_arvalid_r || mem_arready;
  assign elig0_s     = s0_arvalid && (cnt0_r < CNT_MAX);
  assign elig1_s     = s1_arvalid && (cnt1_r < CNT_MAX);

  // Round-robin grant; no grant while reset is asserted so nothing is accepted then lost.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (!rst_s && slot_free_s) begin
      if (elig0_s && elig1_s) begin
        grant0_s = !ptr_r;
        grant1_s = ptr_r;
      end else begin
        grant0_s = elig0_s;
        grant1_s = elig1_s;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign s0_arready  = grant0_s;
  assign s1_arready  = grant1_s;
  assign mem_arvalid = mem_arvalid_r;

  // AR slot valid flag and round-robin pointer.
  always_ff @(posedge aclk) begin
    if (rst_s) begin
      mem_arvalid_r <= 1'b0;
      ptr_r         <= 1'b0;
    end else begin
      if (grant0_s || grant1_s) begin
        mem_arvalid_r <= 1'b1;
      end else if (mem_arready) begin
        mem_arvalid_r <= 1'b0;
      end else begin
        mem_arvalid_r <= mem_arvalid_r;
      end
      if (grant0_s) begin
        ptr_r <= 1'b1;
      end else if (grant1_s) begin
        ptr_r <= 1'b0;
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  // Capture the granted request; the payload needs no reset as mem_arvalid qualifies it.
  always_ff @(posedge aclk) begin
    if (grant0_s) begin
      mem_ar_r <= s0_ar_s;
    end else if (grant1_s) begin
      mem_ar_r <= s1_ar_s;
    end else begin
      mem_ar_r <= mem_ar_r;
    end
  end

  // s0 wins when both masks match, so a shared ID bit pattern never reaches both slaves.
  assign hit0_s = (mem_rid & S0_MASK) == S0_MASK;
  assign hit1_s = !hit0_s && ((mem_rid & S1_MASK) == S1_MASK);

  // R steering: owning slave gets valid and drives ready; unmatched beats are sunk.
  always_comb begin
    s0_rvalid  = mem_rvalid && hit0_s;
    s1_rvalid  = mem_rvalid && hit1_s;
    mem_rready = 1'b1;
    if (hit0_s) begin
      mem_rready = s0_rready;
    end else if (hit1_s) begin
      mem_rready = s1_rready;
    end else begin
      mem_rready = 1'b1;
    end
  end

  assign s0_rid   = mem_rid;
  assign s0_rresp = mem_rresp;
  assign s0_rdata = mem_rdata;
  assign s0_rlast = mem_rlast;
  assign s1_rid   = mem_rid;
  assign s1_rresp = mem_rresp;
  assign s1_rdata = mem_rdata;
  assign s1_rlast = mem_rlast;

  assign dec0_s = s0_rvalid && s0_rready && mem_rlast;
  assign dec1_s = s1_rvalid && s1_rready && mem_rlast;

  // Outstanding burst counters and sticky routing error flag.
  always_ff @(posedge aclk) begin
    if (rst_s) begin
      cnt0_r      <= '0;
      cnt1_r      <= '0;
      route_err_r <= 1'b0;
    end else begin
      cnt0_r <= cnt_next(cnt0_r, grant0_s, dec0_s);
      cnt1_r <= cnt_next(cnt1_r, grant1_s, dec1_s);
      if (mem_rvalid && !hit0_s && !hit1_s) begin
        route_err_r <= 1'b1;
      end else begin
        route_err_r <= route_err_r;
      end
    end
  end

  assign route_err = route_err_r;

endmodule
